mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting NREQ requesters one at a time onto a single memory port.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_wr_rd,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]      req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic                       err,
  output logic                       m_valid,
  output logic                       m_wr_rd,
  output logic [ADDR_WIDTH-1:0]      m_addr,
  output logic [WIDTH-1:0]           m_wdata,
  input  logic [WIDTH-1:0]           m_rdata,
  input  logic                       m_ready
);

  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [NREQ-1:0]         gnt_q, gnt_d;
  logic [NREQ-1:0]         done_q, done_d;
  logic [WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_wr_rd_q, m_wr_rd_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [WIDTH-1:0]        m_wdata_q, m_wdata_d;

  logic                    pick_found;
  logic [ID_W-1:0]         pick_id;
  logic [ID_W-1:0]         cand;
  logic [ADDR_WIDTH-1:0]   addr_a  [NREQ];
  logic [WIDTH-1:0]        wdata_a [NREQ];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
`endif

  // Unpack the per-requester command buses
  for (genvar k = 0; k < int'(NREQ); k++) begin : g_unpack
    assign addr_a[k]  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[k] = req_wdata[k*WIDTH +: WIDTH];
  end

  // Round-robin search starting at ptr, wrapping at NREQ-1
  always_comb begin
    pick_found = 1'b0;
    pick_id    = ptr_q;
    cand       = ptr_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
      cand = (cand == ID_W'(NREQ - 1)) ? '0 : cand + ID_W'(1);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rsp_rdata_d = rsp_rdata_q;
    m_valid_d   = 1'b0;
    m_wr_rd_d   = m_wr_rd_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          id_d           = pick_id;
          gnt_d          = '0;
          gnt_d[pick_id] = 1'b1;
          m_valid_d      = 1'b1;
          m_wr_rd_d      = req_wr_rd[pick_id];
          m_addr_d       = addr_a[pick_id];
          m_wdata_d      = wdata_a[pick_id];
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_ready) begin
          rsp_rdata_d  = m_wr_rd_q ? '0 : m_rdata;
          done_d       = '0;
          done_d[id_q] = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          err_d        = 1'b0;
`endif
          state_d      = S_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_rdata_d  = '0;
          done_d       = '0;
          done_d[id_q] = 1'b1;
          err_d        = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_RESP: begin
        gnt_d   = '0;
        ptr_d   = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      m_valid_q   <= 1'b0;
      m_wr_rd_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      m_valid_q   <= m_valid_d;
      m_wr_rd_q   <= m_wr_rd_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Without the watchdog TIMEOUT has no effect and err is constant 0
  assign err = 1'b0 && (TIMEOUT != 0);
`endif

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign m_valid   = m_valid_q;
  assign m_wr_rd   = m_wr_rd_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of transactions plus reset and watchdog sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req, req_wr_rd, gnt, done;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  rsp_rdata, m_wdata, m_rdata;
  logic        err, m_valid, m_wr_rd, m_ready;
  logic [3:0]  m_addr;

  logic        stall;
  logic        mem_clr;
  logic [7:0]  mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr_rd (req_wr_rd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rsp_rdata (rsp_rdata),
    .err       (err),
    .m_valid   (m_valid),
    .m_wr_rd   (m_wr_rd),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  // Memory responder: completes one cycle after it samples m_valid unless stalled
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h40 + 8'(i);
      m_ready <= 1'b0;
      m_rdata <= 8'h00;
    end else begin
      m_ready <= m_valid && !stall && !rst;
      if (m_valid && !rst) begin
        if (m_wr_rd) mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
      end
    end
  end

  typedef struct {
    bit          rst_first;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [1:0]  id;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string name);
    req       = 4'b0;
    req_wr_rd = 4'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk(name, 32'({gnt, done, rsp_rdata, err, m_valid, m_wr_rd, m_addr, m_wdata}), 32'h0);
    rst = 1'b0;
  endtask

  // One full transaction, entered and left at a negedge with the arbiter idle
  task automatic run_txn(input vec_t v, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << v.id;
    if (v.rst_first) do_reset({tag, " reset"});
    req       = v.req;
    req_wr_rd = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clk);
    chk({tag, " gnt"}, 32'(gnt), 32'(oh));
    chk({tag, " issue"}, 32'({m_valid, m_wr_rd, m_addr, m_wdata}),
        32'({1'b1, v.wr[v.id], 4'(v.addr >> (4 * v.id)), 8'(v.wdata >> (8 * v.id))}));
    @(negedge clk);
    chk({tag, " wait"}, 32'({m_valid, done}), 32'h0);
    @(negedge clk);
    chk({tag, " done"}, 32'({done, err, rsp_rdata}), 32'({oh, 1'b0, v.rdata}));
    @(negedge clk);
    chk({tag, " idle"}, 32'({gnt, done}), 32'h0);
  endtask

  initial begin
    vec_t v;
    logic [3:0] seen;
    //          rst   req      wr       addr      wdata          id     rdata
    vecs[0]  = '{1'b0, 4'b0001, 4'b0001, 16'h0003, 32'h000000A5, 2'd0, 8'h00};
    vecs[1]  = '{1'b0, 4'b0100, 4'b0000, 16'h0300, 32'h00000000, 2'd2, 8'hA5};
    vecs[2]  = '{1'b1, 4'b1111, 4'b0000, 16'h7213, 32'h00000000, 2'd0, 8'hA5};
    vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 16'h7213, 32'h00000000, 2'd1, 8'h41};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 16'h7213, 32'h00000000, 2'd2, 8'h42};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 16'h7213, 32'h00000000, 2'd3, 8'h47};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 16'h7213, 32'h00000000, 2'd0, 8'hA5};
    vecs[7]  = '{1'b0, 4'b1001, 4'b1001, 16'h9005, 32'h33000011, 2'd3, 8'h00};
    vecs[8]  = '{1'b0, 4'b1001, 4'b1001, 16'h9005, 32'h33000011, 2'd0, 8'h00};
    vecs[9]  = '{1'b0, 4'b0010, 4'b0000, 16'h0090, 32'h00000000, 2'd1, 8'h33};
    vecs[10] = '{1'b0, 4'b1000, 4'b0000, 16'h5000, 32'h00000000, 2'd3, 8'h11};
    vecs[11] = '{1'b0, 4'b0010, 4'b0000, 16'h0010, 32'h00000000, 2'd1, 8'h41};

    mem_clr   = 1'b1;
    stall     = 1'b0;
    req       = 4'b0;
    req_wr_rd = 4'b0;
    req_addr  = 16'h0;
    req_wdata = 32'h0;
    @(negedge clk);
    mem_clr = 1'b0;
    do_reset("reset state");

    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while stalled in WAIT: ptr is 2 here, so requester 3 wins
    stall     = 1'b1;
    req       = 4'b1000;
    req_wr_rd = 4'b0000;
    req_addr  = 16'h4000;
    @(negedge clk);
    chk("abort gnt", 32'(gnt), 32'(4'b1000));
    @(negedge clk);
    @(negedge clk);
    chk("abort in wait", 32'({gnt, m_valid, done}), 32'({4'b1000, 1'b0, 4'b0000}));
    rst = 1'b1;
    req = 4'b0;
    @(negedge clk);
    chk("abort reset", 32'({gnt, done, rsp_rdata, err, m_valid, m_wr_rd, m_addr, m_wdata}), 32'h0);
    rst   = 1'b0;
    stall = 1'b0;
    seen  = 4'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen = seen | done | gnt;
    end
    chk("abort no done", 32'(seen), 32'h0);
    // ptr must be back at 0, so requester 0 beats requester 3
    v = '{1'b0, 4'b1001, 4'b0000, 16'h5003, 32'h00000000, 2'd0, 8'hA5};
    run_txn(v, "post abort");

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int         first;
      logic [3:0] d_seen;
      logic       e_seen;
      logic [7:0] r_seen;
      first  = -1;
      d_seen = 4'b0;
      e_seen = 1'b0;
      r_seen = 8'hFF;
      stall     = 1'b1;
      req       = 4'b0100;
      req_wr_rd = 4'b0000;
      req_addr  = 16'h0200;
      for (int c = 1; c <= 20 && first < 0; c++) begin
        @(negedge clk);
        if (done != 4'b0) begin
          first  = c;
          d_seen = done;
          e_seen = err;
          r_seen = rsp_rdata;
        end
      end
      chk("timeout latency", 32'(first), 32'd10);
      chk("timeout resp", 32'({d_seen, e_seen, r_seen}), 32'({4'b0100, 1'b1, 8'h00}));
      req   = 4'b0;
      stall = 1'b0;
      @(negedge clk);
      chk("timeout idle", 32'({gnt, done}), 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
